digit_beep_sequencer: RTL and testbench

- Audio stage between the mouse-click validation logic (isValid / valid_number) and the Audio_Output DAC driver.
- When a validated digit is accepted, it plays that many beeps. Digit 0 plays one long beep.
- Output is a 12-bit square-wave sample. The 20 kHz DAC start strobe samples it asynchronously.
- Replaces the ad-hoc tone logic feeding the speaker in the group task.

---
 rtl/audio_pkg.sv | 17 +
 rtl/square_tone_gen.sv | 35 +++
 rtl/digit_beep_sequencer.sv | 139 +++++++++++++
 tb/tb_digit_beep_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and constants for the digit beep audio path.
package audio_pkg;

    localparam int unsigned SAMPLE_W  = 12;
    localparam int unsigned MAX_DIGIT = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TONE = 2'd1,
        GAP  = 2'd2
    } state_t;

    function automatic int unsigned cycles_per_ms(input int unsigned clk_hz);
        return clk_hz / 1000;
    endfunction

endpackage

// File: rtl/square_tone_gen.sv
// Square-wave phase generator: toggles o_phase every HP enabled cycles.
// Disabled or cleared, it parks with the count at 0 and the phase high.
module square_tone_gen #(
    parameter int unsigned HP = 5
) (
    input  logic clock,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_clear,
    output logic o_phase
);

    localparam int unsigned CNT_W = (HP > 1) ? $clog2(HP) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_phase;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (i_clear || !i_en) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else if (r_cnt == CNT_W'(HP - 1)) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_phase = r_phase;

endmodule

// File: rtl/digit_beep_sequencer.sv
// Plays N beeps for an accepted digit N (one long beep for 0) as a 12-bit square wave.
// Optional build macro BEEP_RETRIGGER_EN: a valid edge while busy restarts the sequence.
module digit_beep_sequencer
    import audio_pkg::*;
#(
    parameter int unsigned         CLK_HZ  = 100_000_000,
    parameter int unsigned         TONE_HZ = 400,
    parameter int unsigned         BEEP_MS = 150,
    parameter int unsigned         GAP_MS  = 100,
    parameter int unsigned         ZERO_MS = 500,
    parameter logic [SAMPLE_W-1:0] AMP     = 12'hFFF
) (
    input  logic                clock,
    input  logic                rst_n,
    input  logic                trig,
    input  logic [3:0]          digit,
    input  logic                mute,
    output logic [SAMPLE_W-1:0] audio_out,
    output logic                busy,
    output logic [3:0]          beeps_left
);

    localparam int unsigned CPM    = cycles_per_ms(CLK_HZ);
    localparam int unsigned HP     = CLK_HZ / (2 * TONE_HZ);
    localparam int unsigned DIV_W  = (CPM > 1) ? $clog2(CPM) : 1;
    localparam int unsigned MAX_MS = (ZERO_MS > BEEP_MS) ?
                                     ((ZERO_MS > GAP_MS) ? ZERO_MS : GAP_MS) :
                                     ((BEEP_MS > GAP_MS) ? BEEP_MS : GAP_MS);
    localparam int unsigned MS_W   = $clog2(MAX_MS + 1);

    state_t           r_state;
    logic             r_trig_d;
    logic [DIV_W-1:0] r_div;
    logic [MS_W-1:0]  r_ms;
    logic [3:0]       r_beeps;
    logic             r_long;

    state_t           w_state_nxt;
    logic [DIV_W-1:0] w_div_nxt;
    logic [MS_W-1:0]  w_ms_nxt;
    logic [3:0]       w_beeps_nxt;
    logic             w_long_nxt;
    logic             w_edge;
    logic             w_accept;
    logic             w_tick;
    logic             w_on_last;
    logic             w_gap_last;
    logic             w_phase;

    assign w_edge = trig & ~r_trig_d;

`ifdef BEEP_RETRIGGER_EN
    assign w_accept = w_edge && (digit <= 4'(MAX_DIGIT));
`else
    assign w_accept = w_edge && (digit <= 4'(MAX_DIGIT)) && (r_state == IDLE);
`endif

    assign w_tick     = (r_div == DIV_W'(CPM - 1));
    assign w_on_last  = (r_ms == (r_long ? MS_W'(ZERO_MS - 1) : MS_W'(BEEP_MS - 1)));
    assign w_gap_last = (r_ms == MS_W'(GAP_MS - 1));

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_trig_d <= 1'b0;
            r_div    <= '0;
            r_ms     <= '0;
            r_beeps  <= '0;
            r_long   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_trig_d <= trig;
            r_div    <= w_div_nxt;
            r_ms     <= w_ms_nxt;
            r_beeps  <= w_beeps_nxt;
            r_long   <= w_long_nxt;
        end
    end

    // Sequencing: ms divider runs only while busy; accept overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_ms_nxt    = r_ms;
        w_beeps_nxt = r_beeps;
        w_long_nxt  = r_long;
        w_div_nxt   = (r_state == IDLE || w_tick) ? '0 : r_div + DIV_W'(1);

        case (r_state)
            TONE: begin
                if (w_tick) begin
                    if (w_on_last) begin
                        w_state_nxt = GAP;
                        w_ms_nxt    = '0;
                        w_beeps_nxt = r_beeps - 4'(1);
                    end else begin
                        w_ms_nxt = r_ms + MS_W'(1);
                    end
                end
            end
            GAP: begin
                if (w_tick) begin
                    if (w_gap_last) begin
                        w_ms_nxt    = '0;
                        w_state_nxt = (r_beeps != 4'(0)) ? TONE : IDLE;
                    end else begin
                        w_ms_nxt = r_ms + MS_W'(1);
                    end
                end
            end
            default: begin
                w_ms_nxt = '0;
            end
        endcase

        if (w_accept) begin
            w_state_nxt = TONE;
            w_div_nxt   = '0;
            w_ms_nxt    = '0;
            w_beeps_nxt = (digit == 4'(0)) ? 4'(1) : digit;
            w_long_nxt  = (digit == 4'(0));
        end
    end

    square_tone_gen #(
        .HP (HP)
    ) u_tone (
        .clock   (clock),
        .rst_n   (rst_n),
        .i_en    (r_state == TONE),
        .i_clear (w_accept),
        .o_phase (w_phase)
    );

    // mute gates the registered phase combinationally so it acts within the cycle.
    assign audio_out  = (w_phase && (r_state == TONE) && !mute) ? AMP : '0;
    assign busy       = (r_state != IDLE);
    assign beeps_left = r_beeps;

endmodule

// File: tb/tb_digit_beep_sequencer.sv
// Randomized self-checking bench for digit_beep_sequencer against a per-cycle timeline model.
module tb_digit_beep_sequencer;

    localparam int CPM  = 10;
    localparam int HP   = 5;
    localparam int BEEP = 3;
    localparam int GAP  = 2;
    localparam int ZERO = 6;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        trig;
    logic [3:0]  digit;
    logic        mute;
    logic [11:0] audio_out;
    logic        busy;
    logic [3:0]  beeps_left;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    digit_beep_sequencer #(
        .CLK_HZ  (10_000),
        .TONE_HZ (1000),
        .BEEP_MS (BEEP),
        .GAP_MS  (GAP),
        .ZERO_MS (ZERO),
        .AMP     (12'hFFF)
    ) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .trig       (trig),
        .digit      (digit),
        .mute       (mute),
        .audio_out  (audio_out),
        .busy       (busy),
        .beeps_left (beeps_left)
    );

    function automatic int seq_len(input int d);
        int nb;
        nb = (d == 0) ? 1 : d;
        return nb * ((((d == 0) ? ZERO : BEEP) + GAP) * CPM);
    endfunction

    // Expected outputs t cycles after the accepting edge (t=0 is the first TONE cycle).
    function automatic void model(input int d, input int t, output logic eb,
                                  output logic [3:0] el, output logic [11:0] ea);
        int nb, on, per, beat, r;
        nb  = (d == 0) ? 1 : d;
        on  = ((d == 0) ? ZERO : BEEP) * CPM;
        per = on + GAP * CPM;
        if (t < 0 || t >= nb * per) begin
            eb = 1'b0; el = 4'd0; ea = 12'h000;
        end else begin
            beat = t / per;
            r    = t % per;
            eb   = 1'b1;
            if (r < on) begin
                el = 4'(nb - beat);
                ea = (((r / HP) % 2) == 0) ? 12'hFFF : 12'h000;
            end else begin
                el = 4'(nb - beat - 1);
                ea = 12'h000;
            end
        end
    endfunction

    // Pulse or hold trig with digit d, optionally fire a second edge at offset ri, and check every cycle.
    task automatic run_digit(input int d, input int hold, input bit rand_mute,
                             input int ri, input int rd, input string tag);
        int n, base, len;
        logic eb;
        logic [3:0] el;
        logic [11:0] ea;
        n    = d;
        base = 0;
        len  = seq_len(d) + 5;
        if (hold + 5 > len) len = hold + 5;
        if (ri >= 0 && ri + 1 + seq_len(rd) + 5 > len) len = ri + 1 + seq_len(rd) + 5;
        trig  = 1'b1;
        digit = 4'(d);
        @(posedge clock);
        for (int t = 0; t < len; t++) begin
            @(negedge clock);
            if (rand_mute) mute = 1'($urandom_range(0, 1));
`ifdef BEEP_RETRIGGER_EN
            if (ri >= 0 && t > ri) begin
                n    = rd;
                base = ri + 1;
            end
`endif
            #1;
            model(n, t - base, eb, el, ea);
            if (mute) ea = 12'h000;
            checks++;
            if (busy !== eb) begin
                errors++;
                $display("FAIL %s busy t=%0d got %b exp %b", tag, t, busy, eb);
            end
            checks++;
            if (beeps_left !== el) begin
                errors++;
                $display("FAIL %s beeps_left t=%0d got %0d exp %0d", tag, t, beeps_left, el);
            end
            checks++;
            if (audio_out !== ea) begin
                errors++;
                $display("FAIL %s audio_out t=%0d got %h exp %h", tag, t, audio_out, ea);
            end
            if (t + 1 == hold) trig = 1'b0;
            if (ri >= 0 && t == ri) begin
                trig  = 1'b1;
                digit = 4'(rd);
            end else if (ri >= 0 && t == ri + 1) begin
                trig = 1'b0;
            end
        end
        trig = 1'b0;
        mute = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        trig  = 1'b0;
        digit = 4'd0;
        mute  = 1'b0;
        #12;
        checks++;
        if (busy !== 1'b0 || beeps_left !== 4'd0 || audio_out !== 12'h000) begin
            errors++;
            $display("FAIL reset got busy=%b left=%0d audio=%h exp 0/0/000", busy, beeps_left, audio_out);
        end
        @(negedge clock);
        rst_n = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if (busy !== 1'b0 || audio_out !== 12'h000) begin
            errors++;
            $display("FAIL reset_idle got busy=%b audio=%h exp 0/000", busy, audio_out);
        end
    endtask

    task automatic test_digits();
        run_digit(3, 1, 1'b0, -1, 0, "digit3");
        run_digit(0, 1, 1'b0, -1, 0, "digit0");
        run_digit(9, 1, 1'b0, -1, 0, "digit9");
        for (int i = 0; i < 4; i++) run_digit(int'($urandom_range(0, 9)), 1, 1'b0, -1, 0, "digit_rand");
    endtask

    task automatic test_invalid();
        for (int i = 0; i < 3; i++) begin
            trig  = 1'b1;
            digit = 4'(10 + $urandom_range(0, 5));
            @(negedge clock);
            trig = 1'b0;
            for (int t = 0; t < 20; t++) begin
                @(negedge clock);
                checks++;
                if (busy !== 1'b0 || audio_out !== 12'h000 || beeps_left !== 4'd0) begin
                    errors++;
                    $display("FAIL invalid_digit t=%0d got busy=%b audio=%h left=%0d exp 0/000/0",
                             t, busy, audio_out, beeps_left);
                end
            end
        end
    endtask

    task automatic test_hold();
        run_digit(2, 200, 1'b0, -1, 0, "hold_high");
    endtask

    task automatic test_mute();
        run_digit(4, 1, 1'b1, -1, 0, "mute_rand");
    endtask

    task automatic test_async_reset();
        trig  = 1'b1;
        digit = 4'd4;
        @(posedge clock);
        @(negedge clock);
        trig = 1'b0;
        @(negedge clock);
        checks++;
        if (busy !== 1'b1 || audio_out !== 12'hFFF || beeps_left !== 4'd4) begin
            errors++;
            $display("FAIL pre_reset got busy=%b audio=%h left=%0d exp 1/fff/4", busy, audio_out, beeps_left);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || audio_out !== 12'h000 || beeps_left !== 4'd0) begin
            errors++;
            $display("FAIL async_reset got busy=%b audio=%h left=%0d exp 0/000/0", busy, audio_out, beeps_left);
        end
        @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || audio_out !== 12'h000) begin
            errors++;
            $display("FAIL post_reset got busy=%b audio=%h exp 0/000", busy, audio_out);
        end
        run_digit(1, 1, 1'b0, -1, 0, "after_reset");
    endtask

    task automatic test_back_to_back();
        run_digit(2, 1, 1'b0, int'($urandom_range(5, 80)), 5, "retrig");
        run_digit(2, 1, 1'b0, int'($urandom_range(5, 80)), 5, "retrig2");
    endtask

    initial begin
        test_reset();
        test_digits();
        test_invalid();
        test_hold();
        test_mute();
        test_async_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
